bus_rr_bridge: RTL and testbench

Parametrised N-channel bridge from hart-side memory ports (instruction fetch, data, future atomics/DMA) onto the single shared external bus. Generalises the fixed two-port IM/DM bus interface: any number of requesters, round-robin arbitration, byte-lane alignment on writes, sign/zero extension on reads, optional bus timeout. Sits between the HART(s) and the top-level bus pins.

---
 rtl/bus_rr_bridge_pkg.sv | 23 ++
 rtl/bus_rr_bridge_arbiter.sv | 30 +++
 rtl/bus_rr_bridge.sv | 221 ++++++++++++++++++++++
 tb/tb_bus_rr_bridge.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bus_rr_bridge_pkg.sv
// Shared definitions for the round-robin bus bridge: funct3 codes, size field, FSM states.
package bus_rr_bridge_pkg;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUS  = 2'd1,
        ST_DONE = 2'd2
    } bus_state_e;

endpackage

// File: rtl/bus_rr_bridge_arbiter.sv
// Round-robin arbiter: search starts one past the last granted channel.
module bus_rr_arbiter #(
    parameter int unsigned N_CH  = 2,
    parameter int unsigned IDX_W = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic [N_CH-1:0]  i_req,
    input  logic [IDX_W-1:0] i_ptr,
    output logic [N_CH-1:0]  o_gnt,
    output logic [IDX_W-1:0] o_idx,
    output logic             o_valid
);

    logic [IDX_W-1:0] cand;

    always_comb begin
        o_gnt   = '0;
        o_idx   = '0;
        o_valid = 1'b0;
        cand    = '0;
        for (int unsigned i = 1; i <= N_CH; i++) begin
            cand = IDX_W'((32'(i_ptr) + i) % N_CH);
            if (!o_valid && i_req[cand]) begin
                o_valid     = 1'b1;
                o_gnt[cand] = 1'b1;
                o_idx       = cand;
            end
        end
    end

endmodule

// File: rtl/bus_rr_bridge.sv
// N-channel requester-to-bus bridge with round-robin grant and lane handling.
// Optional bus timeout enabled by defining ARVI_BUS_TIMEOUT_EN.
module bus_rr_bridge
    import bus_rr_bridge_pkg::*;
#(
    parameter int unsigned N_CH           = 2,
    parameter int unsigned ADDR_W         = 32,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic [N_CH-1:0]      i_req,
    input  logic [N_CH-1:0]      i_wen,
    input  logic [N_CH*ADDR_W-1:0] i_addr,
    input  logic [N_CH*32-1:0]   i_wdata,
    input  logic [N_CH*3-1:0]    i_f3,
    output logic [N_CH-1:0]      o_ready,
    output logic [31:0]          o_rdata,
    output logic [N_CH-1:0]      o_err,
    input  logic                 i_ack,
    input  logic [31:0]          i_rd_data,
    output logic                 o_bus_en,
    output logic                 o_wr_en,
    output logic [31:0]          o_wr_data,
    output logic [ADDR_W-1:0]    o_addr,
    output logic [3:0]           o_byte_en
);

    localparam int unsigned IDX_W = (N_CH > 1) ? $clog2(N_CH) : 1;

    function automatic logic [3:0] lane_mask(input logic [1:0] a, input logic [2:0] f3);
        case (f3[1:0])
            SZ_BYTE: lane_mask = 4'b0001 << a;
            SZ_HALF: lane_mask = 4'b0011 << {a[1], 1'b0};
            default: lane_mask = 4'hF;
        endcase
    endfunction

    function automatic logic [31:0] lane_wdata(input logic [31:0] wd, input logic [2:0] f3);
        case (f3[1:0])
            SZ_BYTE: lane_wdata = {4{wd[7:0]}};
            SZ_HALF: lane_wdata = {2{wd[15:0]}};
            default: lane_wdata = wd;
        endcase
    endfunction

    function automatic logic [31:0] lane_extend(input logic [31:0] rd, input logic [1:0] a,
                                                input logic [2:0] f3);
        logic [31:0] sh;
        logic [15:0] h;
        sh = rd >> {a, 3'b000};
        h  = a[1] ? rd[31:16] : rd[15:0];
        case (f3[1:0])
            SZ_BYTE: lane_extend = {{24{sh[7] & ~f3[2]}}, sh[7:0]};
            SZ_HALF: lane_extend = {{16{h[15] & ~f3[2]}}, h};
            default: lane_extend = rd;
        endcase
    endfunction

    bus_state_e          state_q, state_d;
    logic [IDX_W-1:0]    last_gnt_q, last_gnt_d;
    logic [N_CH-1:0]     gnt_q, gnt_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic                wr_en_q, wr_en_d;
    logic [2:0]          f3_q, f3_d;
    logic [31:0]         wdata_q, wdata_d;
    logic [3:0]          be_q, be_d;
    logic                bus_en_q, bus_en_d;
    logic [N_CH-1:0]     ready_q, ready_d;
    logic [N_CH-1:0]     err_q, err_d;
    logic [31:0]         rdata_q, rdata_d;

    logic [N_CH-1:0]     arb_gnt;
    logic [IDX_W-1:0]    arb_idx;
    logic                arb_valid;
    logic                tmo_hit;

    logic [ADDR_W-1:0]   sel_addr;
    logic                sel_wen;
    logic [31:0]         sel_wdata;
    logic [2:0]          sel_f3;

    bus_rr_arbiter #(
        .N_CH  (N_CH),
        .IDX_W (IDX_W)
    ) u_arb (
        .i_req   (i_req),
        .i_ptr   (last_gnt_q),
        .o_gnt   (arb_gnt),
        .o_idx   (arb_idx),
        .o_valid (arb_valid)
    );

    always_comb begin
        sel_addr  = '0;
        sel_wen   = 1'b0;
        sel_wdata = '0;
        sel_f3    = '0;
        for (int unsigned k = 0; k < N_CH; k++) begin
            if (arb_gnt[k]) begin
                sel_addr  = i_addr[k*ADDR_W +: ADDR_W];
                sel_wen   = i_wen[k];
                sel_wdata = i_wdata[k*32 +: 32];
                sel_f3    = i_f3[k*3 +: 3];
            end
        end
    end

`ifdef ARVI_BUS_TIMEOUT_EN
    localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TMO_W-1:0] tmo_q, tmo_d;

    always_comb begin
        tmo_d   = (state_q == ST_BUS) ? tmo_q + 1'b1 : '0;
        tmo_hit = (state_q == ST_BUS) && !i_ack && (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1));
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) tmo_q <= '0;
        else        tmo_q <= tmo_d;
    end
`else
    always_comb tmo_hit = 1'b0;
`endif

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (arb_valid) state_d = ST_BUS;
            ST_BUS:  if (i_ack || tmo_hit) state_d = ST_DONE;
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Bus outputs are computed one cycle ahead so every pin comes straight from a flop.
    always_comb begin
        last_gnt_d = last_gnt_q;
        gnt_d      = gnt_q;
        addr_d     = addr_q;
        wr_en_d    = wr_en_q;
        f3_d       = f3_q;
        wdata_d    = wdata_q;
        be_d       = be_q;
        bus_en_d   = bus_en_q;
        ready_d    = '0;
        err_d      = '0;
        rdata_d    = '0;
        case (state_q)
            ST_IDLE: begin
                if (arb_valid) begin
                    gnt_d      = arb_gnt;
                    last_gnt_d = arb_idx;
                    addr_d     = sel_addr;
                    wr_en_d    = sel_wen;
                    f3_d       = sel_f3;
                    wdata_d    = lane_wdata(sel_wdata, sel_f3);
                    be_d       = lane_mask(sel_addr[1:0], sel_f3);
                    bus_en_d   = 1'b1;
                end
            end
            ST_BUS: begin
                if (i_ack) begin
                    bus_en_d = 1'b0;
                    wr_en_d  = 1'b0;
                    ready_d  = gnt_q;
                    rdata_d  = wr_en_q ? '0 : lane_extend(i_rd_data, addr_q[1:0], f3_q);
                end else if (tmo_hit) begin
                    bus_en_d = 1'b0;
                    wr_en_d  = 1'b0;
                    ready_d  = gnt_q;
                    err_d    = gnt_q;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            last_gnt_q <= IDX_W'(N_CH - 1);
            gnt_q      <= '0;
            addr_q     <= '0;
            wr_en_q    <= 1'b0;
            f3_q       <= '0;
            wdata_q    <= '0;
            be_q       <= '0;
            bus_en_q   <= 1'b0;
            ready_q    <= '0;
            err_q      <= '0;
            rdata_q    <= '0;
        end else begin
            last_gnt_q <= last_gnt_d;
            gnt_q      <= gnt_d;
            addr_q     <= addr_d;
            wr_en_q    <= wr_en_d;
            f3_q       <= f3_d;
            wdata_q    <= wdata_d;
            be_q       <= be_d;
            bus_en_q   <= bus_en_d;
            ready_q    <= ready_d;
            err_q      <= err_d;
            rdata_q    <= rdata_d;
        end
    end

    assign o_ready   = ready_q;
    assign o_rdata   = rdata_q;
    assign o_err     = err_q;
    assign o_bus_en  = bus_en_q;
    assign o_wr_en   = wr_en_q;
    assign o_wr_data = wdata_q;
    assign o_addr    = addr_q;
    assign o_byte_en = be_q;

endmodule

// File: tb/tb_bus_rr_bridge.sv
// Bench for bus_rr_bridge (3 channels): directed steps plus randomized traffic vs a reference model.
module tb_bus_rr_bridge;

    localparam int unsigned N  = 3;
    localparam int unsigned AW = 32;
`ifdef ARVI_BUS_TIMEOUT_EN
    localparam int unsigned TMO = 4;
`else
    localparam int unsigned TMO = 255;
`endif

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [N-1:0]    req = '0;
    logic [N-1:0]    wen = '0;
    logic [N*AW-1:0] addr_v;
    logic [N*32-1:0] wdata_v;
    logic [N*3-1:0]  f3_v;
    logic [N-1:0]    ready;
    logic [31:0]     rdata;
    logic [N-1:0]    err;
    logic            ack = 1'b0;
    logic [31:0]     rd_data = '0;
    logic            bus_en, wr_en;
    logic [31:0]     wr_data;
    logic [AW-1:0]   addr;
    logic [3:0]      byte_en;

    logic [AW-1:0]   ch_addr  [N];
    logic [31:0]     ch_wdata [N];
    logic [2:0]      ch_f3    [N];

    int              errors = 0;
    int              checks = 0;
    int unsigned     last_gnt;
    int unsigned     last_w;
    logic [31:0]     last_rdata;
    logic [N-1:0]    keep = '0;

    always #5 clk = ~clk;

    always_comb begin
        addr_v  = '0;
        wdata_v = '0;
        f3_v    = '0;
        for (int k = 0; k < N; k++) begin
            addr_v[k*AW +: AW] = ch_addr[k];
            wdata_v[k*32 +: 32] = ch_wdata[k];
            f3_v[k*3 +: 3]      = ch_f3[k];
        end
    end

    bus_rr_bridge #(
        .N_CH           (N),
        .ADDR_W         (AW),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .i_clk     (clk),
        .i_rst     (rst_n),
        .i_req     (req),
        .i_wen     (wen),
        .i_addr    (addr_v),
        .i_wdata   (wdata_v),
        .i_f3      (f3_v),
        .o_ready   (ready),
        .o_rdata   (rdata),
        .o_err     (err),
        .i_ack     (ack),
        .i_rd_data (rd_data),
        .o_bus_en  (bus_en),
        .o_wr_en   (wr_en),
        .o_wr_data (wr_data),
        .o_addr    (addr),
        .o_byte_en (byte_en)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Next grant: first pending channel above the last winner, wrapping to the lowest.
    function automatic int unsigned next_winner(input logic [N-1:0] pend, input int unsigned last);
        for (int unsigned c = last + 1; c < N; c++) if (pend[c]) return c;
        for (int unsigned c = 0; c <= last; c++) if (pend[c]) return c;
        return N;
    endfunction

    function automatic int unsigned size_bytes(input logic [2:0] f3);
        if (f3[1:0] == 2'b00) return 1;
        if (f3[1:0] == 2'b01) return 2;
        return 4;
    endfunction

    function automatic logic [3:0] exp_be(input logic [AW-1:0] a, input logic [2:0] f3);
        int unsigned n, first;
        logic [3:0] m;
        n = size_bytes(f3);
        first = (n == 4) ? 0 : (32'(a[1:0]) / n) * n;
        m = '0;
        for (int unsigned b = 0; b < 4; b++) if (b >= first && b < first + n) m[b] = 1'b1;
        return m;
    endfunction

    function automatic logic [31:0] exp_wd(input logic [31:0] wd, input logic [2:0] f3);
        int unsigned n;
        n = size_bytes(f3);
        if (n == 1) return {24'b0, wd[7:0]} * 32'h0101_0101;
        if (n == 2) return {16'b0, wd[15:0]} * 32'h0001_0001;
        return wd;
    endfunction

    function automatic logic [31:0] exp_rd(input logic [31:0] rd, input logic [AW-1:0] a,
                                           input logic [2:0] f3);
        int unsigned n, first;
        logic [31:0] v, span;
        n = size_bytes(f3);
        if (n == 4) return rd;
        first = (32'(a[1:0]) / n) * n;
        span  = 32'd1 << (8 * n);
        v = (rd >> (8 * first)) % span;
        if (!f3[2] && v >= span / 2) v = v - span;
        return v;
    endfunction

    task automatic randomize_ch(input int k);
        ch_addr[k]  = $urandom;
        ch_wdata[k] = $urandom;
        ch_f3[k]    = 3'($urandom_range(0, 7));
        wen[k]      = 1'($urandom_range(0, 1));
    endtask

    task automatic set_ch(input int k, input logic w, input logic [AW-1:0] a,
                          input logic [31:0] wd, input logic [2:0] f3);
        ch_addr[k]  = a;
        ch_wdata[k] = wd;
        ch_f3[k]    = f3;
        wen[k]      = w;
    endtask

    // Called at a falling edge while the DUT is idle with at least one request pending.
    task automatic run_xfer(input int unsigned ack_delay, input logic [31:0] rd);
        int unsigned w, waited;
        logic [AW-1:0] a;
        logic [2:0] f3;
        logic we;
        w = next_winner(req, last_gnt);
        if (w >= N) begin
            chk("no_pending_request", 32'(req), 32'd1);
            return;
        end
        a = ch_addr[w]; f3 = ch_f3[w]; we = wen[w];
        waited = 0;
        do begin
            @(negedge clk);
            waited++;
        end while (!bus_en && waited < 10);
        chk("grant_latency", waited, 1);
        chk("addr", addr, a);
        chk("byte_en", byte_en, exp_be(a, f3));
        chk("wr_en", wr_en, we);
        if (we) chk("wr_data", wr_data, exp_wd(ch_wdata[w], f3));
        for (int unsigned d = 0; d < ack_delay; d++) begin
            @(negedge clk);
            chk("bus_en_hold", bus_en, 1);
            chk("addr_hold", addr, a);
        end
        ack = 1'b1;
        rd_data = rd;
        @(negedge clk);
        ack = 1'b0;
        rd_data = $urandom;
        chk("ready", ready, 32'd1 << w);
        chk("bus_en_done", bus_en, 0);
        chk("rdata", rdata, we ? 32'd0 : exp_rd(rd, a, f3));
        chk("err", err, 0);
        last_rdata = rdata;
        last_gnt = w;
        last_w = w;
        req[w] = 1'b0;
        @(negedge clk);
        chk("ready_pulse", ready, 0);
        if (keep[w]) begin
            randomize_ch(int'(w));
            req[w] = 1'b1;
        end
    endtask

    initial begin
        int unsigned cnt;
        for (int k = 0; k < N; k++) randomize_ch(k);
        last_gnt = N - 1;

        // reset state
        repeat (3) @(negedge clk);
        chk("rst_bus_en", bus_en, 0);
        chk("rst_wr_en", wr_en, 0);
        chk("rst_addr", addr, 0);
        chk("rst_byte_en", byte_en, 0);
        chk("rst_wr_data", wr_data, 0);
        chk("rst_ready", ready, 0);
        chk("rst_rdata", rdata, 0);
        chk("rst_err", err, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // LW ch1 0x100
        set_ch(1, 1'b0, 32'h100, 32'h0, 3'b010);
        req = 3'b010;
        run_xfer(0, 32'hDEAD_BEEF);
        chk("lw_rdata", last_rdata, 32'hDEAD_BEEF);
        chk("lw_chan", last_w, 1);

        // SB ch1 0x203
        set_ch(1, 1'b1, 32'h203, 32'h5A, 3'b000);
        req = 3'b010;
        run_xfer(1, 32'h0);

        // load extensions
        set_ch(0, 1'b0, 32'h2, 32'h0, 3'b000);
        req = 3'b001;
        run_xfer(0, 32'h0080_0000);
        chk("lb_rdata", last_rdata, 32'hFFFF_FF80);
        set_ch(2, 1'b0, 32'h2, 32'h0, 3'b100);
        req = 3'b100;
        run_xfer(2, 32'h0080_0000);
        chk("lbu_rdata", last_rdata, 32'h0000_0080);
        set_ch(1, 1'b0, 32'h2, 32'h0, 3'b001);
        req = 3'b010;
        run_xfer(0, 32'h8001_0000);
        chk("lh_rdata", last_rdata, 32'hFFFF_8001);

        // round robin: ch0/ch1 continuous, then ch2 joins
        keep = 3'b011;
        randomize_ch(0); randomize_ch(1);
        req = 3'b011;
        for (int i = 0; i < 6; i++) run_xfer(0, $urandom);
        keep = 3'b111;
        randomize_ch(2);
        req[2] = 1'b1;
        for (int i = 0; i < 9; i++) run_xfer(32'($urandom_range(0, 1)), $urandom);
        keep = '0;
        while (req != '0) run_xfer(0, $urandom);

        // randomized traffic
        for (int i = 0; i < 60; i++) begin
            for (int k = 0; k < N; k++) begin
                if (!req[k] && $urandom_range(0, 1) == 1) begin
                    randomize_ch(k);
                    req[k] = 1'b1;
                end
            end
            if (req == '0) begin
                randomize_ch(0);
                req[0] = 1'b1;
            end
            run_xfer(32'($urandom_range(0, 3)), $urandom);
        end
        while (req != '0) run_xfer(0, $urandom);

        // asynchronous reset while the bus is busy
        set_ch(1, 1'b0, 32'h40, 32'h0, 3'b010);
        req = 3'b010;
        @(negedge clk);
        chk("pre_rst_bus_en", bus_en, 1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_bus_en", bus_en, 0);
        chk("mid_rst_ready", ready, 0);
        repeat (2) @(negedge clk);
        chk("mid_rst_ready_later", ready, 0);
        rst_n = 1'b1;
        last_gnt = N - 1;
        randomize_ch(0); randomize_ch(1);
        req = 3'b011;
        run_xfer(0, $urandom);
        chk("post_rst_winner", last_w, 0);
        while (req != '0) run_xfer(0, $urandom);

`ifdef ARVI_BUS_TIMEOUT_EN
        // acknowledge on the terminal cycle completes normally
        randomize_ch(2);
        req = 3'b100;
        run_xfer(TMO - 1, $urandom);

        // no acknowledge: timeout
        set_ch(2, 1'b0, 32'h80, 32'h0, 3'b010);
        req = 3'b100;
        @(negedge clk);
        cnt = 0;
        while (bus_en && cnt < 20) begin
            cnt++;
            @(negedge clk);
        end
        chk("tmo_bus_cycles", cnt, TMO);
        chk("tmo_ready", ready, 3'b100);
        chk("tmo_err", err, 3'b100);
        chk("tmo_rdata", rdata, 0);
        req = '0;
        last_gnt = 2;
        @(negedge clk);
        chk("tmo_ready_clear", ready, 0);
        chk("tmo_err_clear", err, 0);
`else
        cnt = 0;
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
